// File: rtl/strobe_sequencer.sv
// strobe_sequencer
//   Generates single-cycle enable strobes for the capture register with a
//   programmable period. Supports free-run (start), fixed-length bursts
//   (single) and immediate abort (stop).
// Ports:
//   clk50m_i     - 50 MHz clock, rising edge
//   rst_n_i      - asynchronous active-low reset
//   period_i     - strobe period in cycles (0 treated as 1), latched on accept
//   burst_len_i  - strobes per burst (0 treated as 1), latched on single
//   start_i      - enter free-run
//   single_i     - run one burst
//   stop_i       - abort to IDLE (highest priority)
//   enable_o     - registered one-cycle strobe
//   busy_o       - high in RUN or BURST
//   done_o       - one-cycle pulse on natural burst completion
//   state_o      - IDLE=0, RUN=1, BURST=2
module strobe_sequencer #(
  parameter int CNT_W = 26,
  parameter int LEN_W = 8
) (
  input  logic             clk50m_i,
  input  logic             rst_n_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic             start_i,
  input  logic             single_i,
  input  logic             stop_i,
  output logic             enable_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             en_q, en_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] p_eff;
  logic [LEN_W-1:0] l_eff;

  always_comb begin
    p_eff = (period_i == '0) ? CNT_ONE : period_i;
    l_eff = (burst_len_i == '0) ? LEN_ONE : burst_len_i;

    state_d = state_q;
    per_d   = per_q;
    rem_d   = rem_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    // Saturating down-count on every non-strobe cycle.
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q;

    case (state_q)
      S_IDLE: begin
        if (stop_i) begin
          // stop wins over start/single in the same cycle
        end else if (start_i) begin
          state_d = S_RUN;
          per_d   = p_eff;
          cnt_d   = p_eff - CNT_ONE;
          en_d    = 1'b1;
        end else if (single_i) begin
          state_d = S_BURST;
          per_d   = p_eff;
          cnt_d   = p_eff - CNT_ONE;
          // The acceptance strobe is the first of the burst.
          rem_d   = l_eff - LEN_ONE;
          en_d    = 1'b1;
        end
      end
      S_RUN: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          en_d  = 1'b1;
          cnt_d = per_q - CNT_ONE;
        end
      end
      S_BURST: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (en_q && rem_q == '0) begin
          // The strobe just issued was the last one; finish one cycle later.
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          en_d  = 1'b1;
          cnt_d = per_q - CNT_ONE;
          if (rem_q != '0) rem_d = rem_q - LEN_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= CNT_ONE;
      rem_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      rem_q   <= rem_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign enable_o = en_q;
  assign done_o   = done_q;
  assign state_o  = state_q;
  assign busy_o   = (state_q == S_RUN) || (state_q == S_BURST);

endmodule

// File: tb/tb_strobe_sequencer.sv
module tb_strobe_sequencer;
  localparam int CNT_W = 26;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] period = '0;
  logic [LEN_W-1:0] blen = '0;
  logic             start = 1'b0, single = 1'b0, stop = 1'b0;
  logic             en, busy, done;
  logic [1:0]       st;

  int n_cmp = 0;
  int n_err = 0;

  strobe_sequencer #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk50m_i(clk), .rst_n_i(rst_n), .period_i(period), .burst_len_i(blen),
    .start_i(start), .single_i(single), .stop_i(stop),
    .enable_o(en), .busy_o(busy), .done_o(done), .state_o(st)
  );

  always #10 clk = ~clk;

  // Advance past the next rising edge; sampling/driving happens 1 ns later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    start = 1'b0; single = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr();
    tick(); tick();
    n_cmp++; if ({en, busy, done, st} !== 5'b0) begin n_err++;
      $display("FAIL reset_outputs: got en=%b busy=%b done=%b st=%0d, want all 0", en, busy, done, st); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if ({en, busy, st} !== 4'b0) begin n_err++;
      $display("FAIL reset_release_idle: got en=%b busy=%b st=%0d, want 0", en, busy, st); end
  endtask

  task automatic test_run();
    logic exp_en;
    period = 4; start = 1'b1;
    tick(); clr();
    for (int off = 0; off <= 14; off++) begin
      if (off > 0) tick();
      exp_en = (off % 4 == 0);
      n_cmp++; if (en !== exp_en || busy !== 1'b1 || st !== 2'd1 || done !== 1'b0) begin n_err++;
        $display("FAIL run_p4 off=%0d: got en=%b busy=%b st=%0d done=%b, want en=%b busy=1 st=1 done=0",
                 off, en, busy, st, done, exp_en); end
    end
    stop = 1'b1; tick(); clr();
    n_cmp++; if (en !== 1'b0 || st !== 2'd0 || busy !== 1'b0) begin n_err++;
      $display("FAIL run_stop: got en=%b st=%0d busy=%b, want 0/0/0", en, st, busy); end
  endtask

  task automatic test_burst();
    logic exp_en, exp_done; logic [1:0] exp_st;
    period = 3; blen = 5; single = 1'b1;
    tick(); clr();
    for (int off = 0; off <= 15; off++) begin
      if (off > 0) tick();
      exp_en   = (off <= 12) && (off % 3 == 0);
      exp_done = (off == 13);
      exp_st   = (off <= 12) ? 2'd2 : 2'd0;
      n_cmp++; if (en !== exp_en || done !== exp_done || st !== exp_st) begin n_err++;
        $display("FAIL burst_p3_l5 off=%0d: got en=%b done=%b st=%0d, want en=%b done=%b st=%0d",
                 off, en, done, st, exp_en, exp_done, exp_st); end
    end
  endtask

  task automatic test_zero_and_p1();
    period = 0; blen = 0; single = 1'b1;
    tick(); clr();
    n_cmp++; if (en !== 1'b1 || st !== 2'd2) begin n_err++;
      $display("FAIL zero_first: got en=%b st=%0d, want 1/2", en, st); end
    tick();
    n_cmp++; if (en !== 1'b0 || done !== 1'b1 || st !== 2'd0 || busy !== 1'b0) begin n_err++;
      $display("FAIL zero_done: got en=%b done=%b st=%0d busy=%b, want 0/1/0/0", en, done, st, busy); end
    tick();
    n_cmp++; if (done !== 1'b0 || en !== 1'b0) begin n_err++;
      $display("FAIL zero_done_drop: got done=%b en=%b, want 0/0", done, en); end
    period = 1; start = 1'b1;
    tick(); clr();
    for (int off = 0; off < 6; off++) begin
      if (off > 0) tick();
      n_cmp++; if (en !== 1'b1 || st !== 2'd1) begin n_err++;
        $display("FAIL p1_run off=%0d: got en=%b st=%0d, want 1/1", off, en, st); end
    end
    stop = 1'b1; tick(); clr();
    n_cmp++; if (en !== 1'b0 || st !== 2'd0) begin n_err++;
      $display("FAIL p1_stop: got en=%b st=%0d, want 0/0", en, st); end
  endtask

  task automatic test_stop_and_busy_cmds();
    logic exp_en; logic [1:0] exp_st;
    period = 5; start = 1'b1;
    tick(); clr();
    for (int off = 1; off <= 11; off++) begin
      tick(); clr();
      // Stop lands on edge 10, where cnt is 0: the strobe must be suppressed.
      exp_en = (off < 10) && (off % 5 == 0);
      exp_st = (off < 10) ? 2'd1 : 2'd0;
      n_cmp++; if (en !== exp_en || st !== exp_st || done !== 1'b0) begin n_err++;
        $display("FAIL stop_p5 off=%0d: got en=%b st=%0d done=%b, want en=%b st=%0d done=0",
                 off, en, st, done, exp_en, exp_st); end
      if (off == 1) begin start = 1'b1; period = 2; end
      if (off == 5) begin single = 1'b1; blen = 1; end
      if (off == 9) stop = 1'b1;
    end
  endtask

  task automatic test_simultaneous();
    logic exp_en;
    period = 4; blen = 3; start = 1'b1; single = 1'b1;
    tick(); clr();
    period = 2;
    n_cmp++; if (st !== 2'd1 || en !== 1'b1) begin n_err++;
      $display("FAIL start_single_prio: got st=%0d en=%b, want 1/1", st, en); end
    for (int off = 1; off <= 12; off++) begin
      tick();
      exp_en = (off % 4 == 0);
      n_cmp++; if (en !== exp_en) begin n_err++;
        $display("FAIL period_latched off=%0d: got en=%b, want %b", off, en, exp_en); end
    end
    stop = 1'b1; tick(); clr();
    stop = 1'b1; start = 1'b1; tick(); clr();
    n_cmp++; if (st !== 2'd0 || en !== 1'b0 || busy !== 1'b0) begin n_err++;
      $display("FAIL stop_start_prio: got st=%0d en=%b busy=%b, want 0/0/0", st, en, busy); end
  endtask

  task automatic test_back_to_back();
    logic exp_en, exp_done; logic [1:0] exp_st;
    period = 2; blen = 2; single = 1'b1;
    tick(); clr();
    for (int off = 1; off <= 8; off++) begin
      tick(); clr();
      // First burst: strobes 0,2, done at 3. Second (P=1,L=3) accepted at 4.
      exp_en   = (off == 2) || (off >= 4 && off <= 6);
      exp_done = (off == 3) || (off == 7);
      exp_st   = (off == 3 || off >= 7) ? 2'd0 : 2'd2;
      n_cmp++; if (en !== exp_en || done !== exp_done || st !== exp_st) begin n_err++;
        $display("FAIL back_to_back off=%0d: got en=%b done=%b st=%0d, want en=%b done=%b st=%0d",
                 off, en, done, st, exp_en, exp_done, exp_st); end
      if (off == 3) begin single = 1'b1; period = 1; blen = 3; end
    end
  endtask

  task automatic test_async_reset();
    logic exp_en, exp_done; logic [1:0] exp_st;
    period = 3; blen = 5; single = 1'b1;
    tick(); clr();
    for (int off = 1; off <= 6; off++) tick();
    n_cmp++; if (en !== 1'b1 || st !== 2'd2) begin n_err++;
      $display("FAIL areset_pre: got en=%b st=%0d, want 1/2", en, st); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if ({en, busy, done, st} !== 5'b0) begin n_err++;
      $display("FAIL areset_immediate: got en=%b busy=%b done=%b st=%0d, want all 0", en, busy, done, st); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (done !== 1'b0 || en !== 1'b0) begin n_err++;
        $display("FAIL areset_hold: got done=%b en=%b, want 0/0", done, en); end
    end
    rst_n = 1'b1;
    tick(); tick();
    period = 2; blen = 2; single = 1'b1;
    tick(); clr();
    for (int off = 0; off <= 4; off++) begin
      if (off > 0) tick();
      exp_en   = (off == 0) || (off == 2);
      exp_done = (off == 3);
      exp_st   = (off <= 2) ? 2'd2 : 2'd0;
      n_cmp++; if (en !== exp_en || done !== exp_done || st !== exp_st) begin n_err++;
        $display("FAIL post_reset_burst off=%0d: got en=%b done=%b st=%0d, want en=%b done=%b st=%0d",
                 off, en, done, st, exp_en, exp_done, exp_st); end
    end
  endtask

  initial begin
    test_reset();
    // Move the first command to edge 10 after reset release.
    for (int i = 0; i < 5; i++) tick();
    test_run();
    tick();
    test_burst();
    test_zero_and_p1();
    tick();
    test_stop_and_busy_cmds();
    tick();
    test_simultaneous();
    tick();
    test_back_to_back();
    tick();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, want completion");
    $fatal(1);
  end
endmodule

// File: doc/strobe_sequencer.md
# strobe_sequencer

Timing controller for the enable-gated capture register in the board top level. It generates single-cycle `enable_o` strobes on the 50 MHz clock with a programmable period. It supports free-running operation, fixed-length bursts and immediate stop. It replaces the fixed-rate enable generator, so software or button logic can decide when and how often the key-to-LED register samples.

## Interface
- `CNT_W`, 26: width of the period counter; covers 1 s at 50 MHz.
- `LEN_W`, 8: width of the burst length.
- `clk50m_i` in 1: 50 MHz system clock; all logic on its rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `period_i` in CNT_W: strobe period in clock cycles; sampled only when a start or single command is accepted.
- `burst_len_i` in LEN_W: number of strobes in a burst; sampled with `single_i`.
- `start_i` in 1: one-cycle command to enter free-run.
- `single_i` in 1: one-cycle command to run one burst.
- `stop_i` in 1: one-cycle command to abort and return to IDLE.
- `enable_o` out 1: registered one-cycle strobe to the data register's enable.
- `busy_o` out 1: high in RUN or BURST.
- `done_o` out 1: one-cycle pulse on natural burst completion.
- `state_o` out 2: current state; IDLE=0, RUN=1, BURST=2; value 3 is unused.

## Operation
- Effective values:
  - P = `period_i`, or 1 if `period_i` is 0.
  - L = `burst_len_i`, or 1 if `burst_len_i` is 0.
  - Both are latched into internal registers at command acceptance.
  - `period_i` and `burst_len_i` changes while busy are ignored.
- States:
  - IDLE: `enable_o`=0.
    - `start_i` → RUN.
    - `single_i` → BURST.
  - RUN: strobes every P cycles indefinitely.
    - `stop_i` → IDLE.
  - BURST: strobes every P cycles.
    - After the L-th strobe → IDLE with `done_o`.
    - `stop_i` → IDLE without `done_o`.
- Command priority within one cycle: stop > start > single.
  - In IDLE, stop+start leaves the block in IDLE.
  - In IDLE, start+single enters RUN.
- `start_i` and `single_i` are ignored while busy; they are not queued.
- `stop_i` in IDLE has no effect.
- Down-counter `cnt` (CNT_W bits):
  - Loaded with P-1 on every strobe.
  - Decremented otherwise.
  - A strobe fires when `cnt`==0 in RUN or BURST.
- Remaining-strobe counter `rem` (LEN_W bits):
  - Loaded with L-1 on burst acceptance, because the first strobe is counted.
  - Decremented on each later strobe.
  - A strobe issued with `rem`==0 is the last strobe.
- No arithmetic wraps: `cnt` and `rem` are never decremented below 0.

## Timing
- Edge t0: a command is sampled high at the rising edge t0 and accepted.
  - `enable_o`=1 after edge t0, so the consumer captures at edge t0+1.
  - `state_o` and `busy_o` update at edge t0.
- Further strobes: `enable_o`=1 after edges t0+P, t0+2P, …; low at all other times.
- P=1: `enable_o` is held high continuously in RUN.
- Burst end: the last strobe is set at edge t0+(L-1)P.
  - At edge t0+(L-1)P+1: `enable_o`=0, `done_o`=1, `state_o`=IDLE, `busy_o`=0.
  - `done_o` drops at the next edge.
- Back-to-back burst: a new `single_i` is accepted in the first cycle in which IDLE is visible, including the `done_o` cycle.
- Stop: `stop_i` sampled at edge ts.
  - `enable_o`=0, `state_o`=IDLE and `busy_o`=0 after edge ts.
  - Applies even when `cnt` was 0; the strobe is suppressed.
- Reset:
  - `rst_n_i` low forces, asynchronously: `enable_o`=0, `busy_o`=0, `done_o`=0, `state_o`=IDLE, `cnt`=0, `rem`=0.
  - Reset in the middle of RUN or BURST emits no `done_o`.
  - Deassertion needs no command to be held; the block stays in IDLE until a command arrives.

## Test plan
- Reset, then `start_i` at edge 10 with `period_i`=4 → `enable_o` high after edges 10, 14, 18, 22; `busy_o`=1, `state_o`=1; `done_o` never pulses.
- `single_i` with `period_i`=3 and `burst_len_i`=5 at edge 0 → strobes after edges 0, 3, 6, 9, 12; `done_o`=1 and `state_o`=0 after edge 13 only.
- `period_i`=0 and `burst_len_i`=0 with `single_i` → exactly one strobe, then `done_o` the next cycle; `period_i`=1 with `start_i` → `enable_o` high every cycle.
- RUN with P=5; `stop_i` at the edge where `cnt`=0 → no strobe at that edge, IDLE next cycle; `start_i` and `single_i` while busy → no effect on the strobe pattern.
- Simultaneous commands in IDLE: start+single → RUN; stop+start → stays IDLE; change `period_i` mid-RUN from 4 to 2 → the period stays 4.
- Assert `rst_n_i` low asynchronously, between clock edges, during BURST strobe 3 of 5 → all outputs 0 immediately, no `done_o`; after release, `single_i` with L=2 yields 2 strobes and `done_o`.
